// File: rtl/sw_ni_tx.sv
// sw_ni_tx - network-interface transmitter for one input port of the 4x4
// packet switch. Turns a host command (destination, length) plus a stream of
// payload words into a head flit followed by len body flits; the last one is
// marked as the tail. A flit is launched only when the switch input buffer
// is not full.
//
// Handshake: a transfer on cvalid/cready or dvalid/dready happens at a rising
// edge where both valid and ready are high. Ready never depends on valid.
// cready is high only in IDLE. dready is high only in BODY with full low.
// Both ready outputs are held low while rst is high.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cvalid/cready     host command handshake; cdst = destination 0..3,
//                     clen = body-flit count 1..MAXLEN
//   dvalid/dready     payload word handshake; ddata = payload word
//   full              switch input buffer full (stalls flit launch)
//   o                 registered flit {v, type[1:0], data[DW-1:0]}
//   err               sticky flag for illegal command lengths
//   pkt_cnt           completed-packet counter, wraps at 256
//   state_dbg         current FSM state (0 IDLE, 1 HEAD, 2 BODY)
module sw_ni_tx #(
    parameter int DW     = 8,
    parameter int MAXLEN = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cvalid,
    output logic          cready,
    input  logic [1:0]    cdst,
    input  logic [2:0]    clen,
    input  logic          dvalid,
    output logic          dready,
    input  logic [DW-1:0] ddata,
    input  logic          full,
    output logic [DW+2:0] o,
    output logic          err,
    output logic [7:0]    pkt_cnt,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAD = 2'd1,
        S_BODY = 2'd2
    } state_t;

    localparam logic [2:0] MAXLEN_L = 3'(MAXLEN);

    state_t        state_q, state_d;
    logic [1:0]    dst_r_q, dst_r_d;
    logic [2:0]    len_r_q, len_r_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [DW+2:0] o_q, o_d;
    logic          err_q, err_d;
    logic [7:0]    pkt_cnt_q, pkt_cnt_d;

    logic [DW-1:0] head_data;
    logic          cmd_ok;
    logic          is_tail;

    // Head payload: one-hot destination in [3:0], length in [6:4], rest zero.
    always_comb begin
        head_data      = '0;
        head_data[3:0] = 4'b0001 << dst_r_q;
        head_data[6:4] = len_r_q;
    end

    assign cmd_ok  = (clen != 3'd0) && (clen <= MAXLEN_L);
    assign is_tail = (cnt_q == 3'(len_r_q - 3'd1));

    always_comb begin
        state_d   = state_q;
        dst_r_d   = dst_r_q;
        len_r_d   = len_r_q;
        cnt_d     = cnt_q;
        o_d       = '0;          // idle flit unless something launches
        err_d     = err_q;
        pkt_cnt_d = pkt_cnt_q;
        cready    = 1'b0;
        dready    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cready = ~rst;
                if (cvalid) begin
                    if (cmd_ok) begin
                        dst_r_d = cdst;
                        len_r_d = clen;
                        cnt_d   = 3'd0;
                        state_d = S_HEAD;
                    end else begin
                        // Illegal length: swallow the command, flag it.
                        err_d = 1'b1;
                    end
                end
            end
            S_HEAD: begin
                if (!full) begin
                    o_d     = {1'b1, 2'b01, head_data};
                    state_d = S_BODY;
                end
            end
            S_BODY: begin
                dready = ~full & ~rst;
                if (dvalid && !full) begin
                    o_d   = {1'b1, (is_tail ? 2'b11 : 2'b10), ddata};
                    cnt_d = cnt_q + 3'd1;
                    if (is_tail) begin
                        state_d   = S_IDLE;
                        pkt_cnt_d = pkt_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            dst_r_q   <= 2'd0;
            len_r_q   <= 3'd0;
            cnt_q     <= 3'd0;
            o_q       <= '0;
            err_q     <= 1'b0;
            pkt_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            dst_r_q   <= dst_r_d;
            len_r_q   <= len_r_d;
            cnt_q     <= cnt_d;
            o_q       <= o_d;
            err_q     <= err_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign o         = o_q;
    assign err       = err_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sw_ni_tx.sv
// Testbench for sw_ni_tx: a table of per-cycle vectors with hand-computed
// expectations, followed by a hand-written run of 256 single-flit packets.
module tb_sw_ni_tx;

    localparam int DW = 8;
    localparam int FW = DW + 3;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cvalid = 1'b0;
    logic          cready;
    logic [1:0]    cdst = 2'd0;
    logic [2:0]    clen = 3'd0;
    logic          dvalid = 1'b0;
    logic          dready;
    logic [DW-1:0] ddata = '0;
    logic          full = 1'b0;
    logic [FW-1:0] o;
    logic          err;
    logic [7:0]    pkt_cnt;
    logic [1:0]    state_dbg;

    sw_ni_tx #(.DW(DW), .MAXLEN(7)) dut (
        .clk(clk), .rst(rst),
        .cvalid(cvalid), .cready(cready), .cdst(cdst), .clen(clen),
        .dvalid(dvalid), .dready(dready), .ddata(ddata),
        .full(full), .o(o), .err(err), .pkt_cnt(pkt_cnt),
        .state_dbg(state_dbg)
    );

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HEAD = 2'd1;
    localparam logic [1:0] ST_BODY = 2'd2;

    typedef struct {
        logic          rst;
        logic          cvalid;
        logic [1:0]    cdst;
        logic [2:0]    clen;
        logic          dvalid;
        logic [DW-1:0] ddata;
        logic          full;
        logic          exp_cready;   // before the edge
        logic          exp_dready;   // before the edge
        logic [FW-1:0] exp_o;        // after the edge
        logic          exp_err;
        logic [7:0]    exp_pkt;
        logic [1:0]    exp_state;
    } vec_t;

    localparam int NV = 36;
    vec_t vecs[NV];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic cv, input logic [1:0] cd, input logic [2:0] cl,
                                input logic dv, input logic [DW-1:0] dd, input logic f,
                                input logic ecr, input logic edr, input logic [FW-1:0] eo,
                                input logic ee, input logic [7:0] ep, input logic [1:0] es);
        vec_t v;
        v.rst = r; v.cvalid = cv; v.cdst = cd; v.clen = cl;
        v.dvalid = dv; v.ddata = dd; v.full = f;
        v.exp_cready = ecr; v.exp_dready = edr; v.exp_o = eo;
        v.exp_err = ee; v.exp_pkt = ep; v.exp_state = es;
        return v;
    endfunction

    // driver: apply inputs, check ready outputs, clock, check registers
    task automatic apply_vec(input int idx, input vec_t v);
        rst = v.rst; cvalid = v.cvalid; cdst = v.cdst; clen = v.clen;
        dvalid = v.dvalid; ddata = v.ddata; full = v.full;
        #1;
        chk("cready", idx, 32'(cready), 32'(v.exp_cready));
        chk("dready", idx, 32'(dready), 32'(v.exp_dready));
        @(posedge clk);
        #1;
        chk("o", idx, 32'(o), 32'(v.exp_o));
        chk("err", idx, 32'(err), 32'(v.exp_err));
        chk("pkt_cnt", idx, 32'(pkt_cnt), 32'(v.exp_pkt));
        chk("state", idx, 32'(state_dbg), 32'(v.exp_state));
    endtask

    // one legal single-flit packet: command, head, tail
    task automatic send_one(input int idx, input logic [7:0] exp_pkt_after);
        rst = 1'b0; full = 1'b0;
        cvalid = 1'b1; cdst = 2'd3; clen = 3'd1; dvalid = 1'b0;
        @(posedge clk); #1;
        cvalid = 1'b0;
        @(posedge clk); #1;
        dvalid = 1'b1; ddata = 8'(idx);
        @(posedge clk); #1;
        dvalid = 1'b0;
        chk("tail_o", idx, 32'(o), 32'({3'b111, 8'(idx)}));
        chk("pkt_wrap", idx, 32'(pkt_cnt), 32'(exp_pkt_after));
    endtask

    initial begin
        // reset
        vecs[0]  = mk(1,0,0,0, 0,8'h00,0, 0,0, 11'h000, 0,0,ST_IDLE);
        // basic packet: dst 2, len 3
        vecs[1]  = mk(0,1,2,3, 1,8'hA1,0, 1,0, 11'h000, 0,0,ST_HEAD);
        vecs[2]  = mk(0,0,0,0, 1,8'hA1,0, 0,0, 11'h534, 0,0,ST_BODY);
        vecs[3]  = mk(0,0,0,0, 1,8'hA1,0, 0,1, 11'h6A1, 0,0,ST_BODY);
        vecs[4]  = mk(0,0,0,0, 1,8'hA2,0, 0,1, 11'h6A2, 0,0,ST_BODY);
        vecs[5]  = mk(0,0,0,0, 1,8'hA3,0, 0,1, 11'h7A3, 0,1,ST_IDLE);
        vecs[6]  = mk(0,0,0,0, 0,8'h00,0, 1,0, 11'h000, 0,1,ST_IDLE);
        // same packet, two full cycles after A1
        vecs[7]  = mk(0,1,2,3, 1,8'hA1,0, 1,0, 11'h000, 0,1,ST_HEAD);
        vecs[8]  = mk(0,0,0,0, 1,8'hA1,0, 0,0, 11'h534, 0,1,ST_BODY);
        vecs[9]  = mk(0,0,0,0, 1,8'hA1,0, 0,1, 11'h6A1, 0,1,ST_BODY);
        vecs[10] = mk(0,0,0,0, 1,8'hA2,1, 0,0, 11'h000, 0,1,ST_BODY);
        vecs[11] = mk(0,0,0,0, 1,8'hA2,1, 0,0, 11'h000, 0,1,ST_BODY);
        vecs[12] = mk(0,0,0,0, 1,8'hA2,0, 0,1, 11'h6A2, 0,1,ST_BODY);
        vecs[13] = mk(0,0,0,0, 1,8'hA3,0, 0,1, 11'h7A3, 0,2,ST_IDLE);
        // back-to-back len=1 commands to dst 1, cvalid held
        vecs[14] = mk(0,1,1,1, 1,8'hB1,0, 1,0, 11'h000, 0,2,ST_HEAD);
        vecs[15] = mk(0,1,1,1, 1,8'hB1,0, 0,0, 11'h512, 0,2,ST_BODY);
        vecs[16] = mk(0,1,1,1, 1,8'hB1,0, 0,1, 11'h7B1, 0,3,ST_IDLE);
        vecs[17] = mk(0,1,1,1, 1,8'hB2,0, 1,0, 11'h000, 0,3,ST_HEAD);
        vecs[18] = mk(0,0,1,1, 1,8'hB2,0, 0,0, 11'h512, 0,3,ST_BODY);
        vecs[19] = mk(0,0,0,0, 1,8'hB2,0, 0,1, 11'h7B2, 0,4,ST_IDLE);
        vecs[20] = mk(0,0,0,0, 0,8'h00,0, 1,0, 11'h000, 0,4,ST_IDLE);
        // len=4 to dst 3, reset after head and one body flit
        vecs[21] = mk(0,1,3,4, 0,8'h00,0, 1,0, 11'h000, 0,4,ST_HEAD);
        vecs[22] = mk(0,0,0,0, 0,8'h00,0, 0,0, 11'h548, 0,4,ST_BODY);
        vecs[23] = mk(0,0,0,0, 1,8'hC1,0, 0,1, 11'h6C1, 0,4,ST_BODY);
        vecs[24] = mk(1,0,0,0, 1,8'hC2,0, 0,0, 11'h000, 0,0,ST_IDLE);
        vecs[25] = mk(0,0,0,0, 1,8'hC2,0, 1,0, 11'h000, 0,0,ST_IDLE);
        // clen=0 (illegal) then len=1 to dst 0
        vecs[26] = mk(0,1,0,0, 0,8'h00,0, 1,0, 11'h000, 1,0,ST_IDLE);
        vecs[27] = mk(0,1,0,1, 0,8'h00,0, 1,0, 11'h000, 1,0,ST_HEAD);
        vecs[28] = mk(0,0,0,0, 1,8'hD1,0, 0,0, 11'h511, 1,0,ST_BODY);
        vecs[29] = mk(0,0,0,0, 1,8'hD1,0, 0,1, 11'h7D1, 1,1,ST_IDLE);
        // head stalled by full, then a bubble in BODY
        vecs[30] = mk(0,1,1,1, 0,8'h00,0, 1,0, 11'h000, 1,1,ST_HEAD);
        vecs[31] = mk(0,0,0,0, 0,8'h00,1, 0,0, 11'h000, 1,1,ST_HEAD);
        vecs[32] = mk(0,0,0,0, 0,8'h00,0, 0,0, 11'h512, 1,1,ST_BODY);
        vecs[33] = mk(0,0,0,0, 0,8'h00,0, 0,1, 11'h000, 1,1,ST_BODY);
        vecs[34] = mk(0,0,0,0, 1,8'hE1,0, 0,1, 11'h7E1, 1,2,ST_IDLE);
        // reset clears err and pkt_cnt
        vecs[35] = mk(1,0,0,0, 0,8'h00,0, 0,0, 11'h000, 0,0,ST_IDLE);

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NV; i++) apply_vec(i, vecs[i]);

        // 256 single-flit packets: counter wraps to 0, err stays clear
        rst = 1'b0;
        for (int i = 0; i < 256; i++) send_one(i, 8'((i + 1) % 256));
        chk("wrap_final", 256, 32'(pkt_cnt), 32'd0);
        chk("err_final", 256, 32'(err), 32'd0);
        chk("state_final", 256, 32'(state_dbg), 32'(ST_IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sw_ni_tx.md
# sw_ni_tx

Network-interface transmitter that drives one input port of the 4x4 packet switch `sw`. It takes host commands (destination, length) and a stream of payload words, and formats them into head/body/tail flits. Flits are injected into the switch input only while the attached input buffer is not full. One instance sits in front of each switch input i0..i3.

## Interface
- DW, 8, payload width in bits (minimum 7). The flit width is DW+3 and must equal the switch packet width at integration.
- MAXLEN, 7, maximum body flits per packet. It must fit in 3 bits.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- cvalid  in  1  host command valid.
- cready  out  1  command accept.
- cdst  in  2  destination port, binary 0..3.
- clen  in  3  body-flit count, 1..MAXLEN.
- dvalid  in  1  payload word valid.
- dready  out  1  payload word accept.
- ddata  in  DW  payload word.
- full  in  1  attached switch input buffer full.
- o  out  DW+3  flit to the switch input. Layout: {v, type[1:0], data[DW-1:0]}.
- err  out  1  sticky illegal-command flag.
- pkt_cnt  out  8  count of completed packets.

## Operation
- Flit types: 00 idle, 01 head, 10 body, 11 tail. An idle flit is all zeros, with v=0.
- Head flit data:
  - data[3:0] = one-hot destination (1<<cdst).
  - data[6:4] = len.
  - data[DW-1:7] = 0.
- The state machine has three states: IDLE, HEAD, BODY. Registers:
  - dst_r[1:0]
  - len_r[2:0]
  - cnt[2:0]
- IDLE:
  - cready=1.
  - On cvalid with clen in 1..MAXLEN: latch cdst and clen, clear cnt, and go to HEAD.
  - On cvalid with clen=0 or clen>MAXLEN: consume the command, set err, stay in IDLE, emit nothing.
- HEAD:
  - If full=0: o <= head flit, go to BODY.
  - Else: o <= 0 and hold.
- BODY:
  - dready = !full.
  - If dvalid and !full:
    - o <= {1, type, ddata}, where type = 11 when cnt==len_r-1, otherwise 10.
    - cnt <= cnt+1.
    - On the tail flit: go to IDLE and set pkt_cnt <= pkt_cnt+1.
  - Otherwise: o <= 0 (a bubble) and no state change.
- cready is 0 outside IDLE. dready is 0 outside BODY.
- pkt_cnt wraps from 255 to 0. err stays set until rst.
- A packet is never interleaved with another packet. Payload words are consumed only in BODY.

## Timing
- o is a register. It carries a non-idle flit for exactly one cycle per transfer and is 0 in every other cycle.
- Reset values:
  - o = 0, err = 0, pkt_cnt = 0, state = IDLE, cnt = 0.
  - cready = 0 and dready = 0 while rst is high.
- Command accepted at edge k → head flit on o after edge k+1 (if full=0 at k+1).
- The first body flit follows the head at edge k+2 at the earliest.
- Packet of len L with no stalls: o is valid for L+1 consecutive cycles starting at k+1.
- Back-to-back packets:
  - Tail at edge t, next command accepted at edge t+1 earliest, next head at edge t+2.
  - This leaves exactly one idle cycle on o between packets.
- Stall rules:
  - full is sampled at the same edge that would launch a flit. full=1 at that edge produces an idle flit and no state change.
  - full=1 in BODY forces dready=0 combinationally, so no payload word is consumed.
- Simultaneous dvalid=0 and full=0 in BODY: a bubble is emitted and the packet stays open indefinitely.
- Reset mid-packet:
  - The packet is abandoned, o=0 from the next edge, and the remaining payload words are not consumed.
  - The downstream switch sees a truncated packet; this is accepted behaviour.

## Test plan
- Reset, then cdst=2, clen=3 with dvalid held high, data A1,A2,A3, full=0 → o sequence:
  - head with v=1, type 01, data 0x34;
  - then body A1, body A2, tail A3;
  - then pkt_cnt=1.
- Same command with full=1 for 2 cycles during BODY after A1 → two idle cycles on o, A2 not consumed (dready=0), then A2 and A3 follow with correct types.
- clen=0 command, then clen=1 to dst 0 → err=1, no flit from the first command, then head data 0x11 followed by a single tail flit.
- Two commands offered continuously, both len=1 → exactly one idle cycle between the first tail and the second head; pkt_cnt=2.
- rst asserted after the head and one body flit of a len=4 packet → o=0 from the next edge, state IDLE, cready=1 after rst drops, err=0, pkt_cnt=0.
- 256 single-flit packets → pkt_cnt wraps to 0; err stays 0.
